mrd_col_sched: RTL and testbench
================================

# mrd_col_sched

Column scheduler that time-shares one MRD_inv iteration engine across all DIMENSION columns of the inverse, instead of instantiating one engine per column. On `start`, it steps through columns 0..DIMENSION-1, and for each column it:
- drives the unit vector e_k into the engine,
- clears and enables the engine for a fixed ITER_NUM×ENG_LAT-cycle window,
- writes the resulting column into the downstream column buffer.

It sits between the top-level matrix-inverse control and a single shared MRD_inv instance. A and M_init are broadcast to that instance directly and are not touched here.

## Interface
- DIMENSION, 16, matrix order; number of columns scheduled
- WIDTH, 8, bits per signed element
- ITER_NUM, 2, engine iterations per column
- ENG_LAT, 4, engine cycles per iteration; RUN window N = ITER_NUM*ENG_LAT
- ONE, 1, signed value written into the active element of e_col (fixed-point 1.0)
- Reset is synchronous, active-low, on `rst`; single clock `clk`.
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-low reset
- start  in  1  begin full inversion; sampled only in IDLE
- abort  in  1  cancel sequence; sampled in every non-IDLE state
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, all DIMENSION columns written
- col_idx  out  $clog2(DIMENSION)  column currently scheduled
- e_col  out  DIMENSION*WIDTH  unit vector to engine `e` input (registered)
- eng_clr  out  1  one-cycle engine state clear before each column
- eng_en  out  1  engine enable during RUN
- eng_result  in  DIMENSION*WIDTH  engine `M_iter_c` output
- wr_en  out  1  column-buffer write strobe
- wr_addr  out  $clog2(DIMENSION)  column-buffer address
- wr_data  out  DIMENSION*WIDTH  column data (registered copy of eng_result)

## Operation
- States: IDLE, CLR, RUN, WR, DONE.
- IDLE:
  - If start=1, go to CLR with col=0 and e_col = ONE in slice [0 +: WIDTH], all other slices 0.
  - If start=0, stay in IDLE.
- CLR (1 cycle): eng_clr=1, eng_en=0. Load run counter to 0. Go to RUN.
- RUN (exactly N cycles): eng_en=1. Counter increments each cycle. On the cycle with counter==N-1, go to WR.
- WR (1 cycle):
  - wr_en=1, wr_addr=col, wr_data=eng_result sampled at the edge ending the last RUN cycle.
  - If col==DIMENSION-1, go to DONE.
  - Otherwise col+1, e_col re-registered with ONE in slice [(col+1)*WIDTH +: WIDTH] and all other slices 0, then go to CLR.
- DONE (1 cycle): done=1, then go to IDLE. col_idx and e_col return to 0 on entering IDLE.
- e_col has exactly one nonzero slice in every non-IDLE state; it is all-zero in IDLE.
- start while busy is ignored; it is not queued.
- abort=1 in any non-IDLE state:
  - next state is IDLE, with col, e_col, eng_en, eng_clr and wr_en cleared;
  - no done pulse is generated;
  - a WR cycle coinciding with abort still performs its write in that cycle;
  - abort has priority over every other transition;
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Counter width is $clog2(N)+1. The counter never wraps within a column.

## Timing
- Reset values: busy=0, done=0, col_idx=0, e_col=0, eng_clr=0, eng_en=0, wr_en=0, wr_addr=0, wr_data=0. State=IDLE.
- rst=0 mid-sequence forces these values at the next edge, identically to abort, and suppresses any pending write.
- All outputs are registered with no combinational input-to-output paths. Outputs reflect the current state.
- start sampled at edge 0 gives, for column k (0-based), P = N+2 cycles per column:
  - CLR in cycle 1+kP,
  - RUN in cycles 2+kP .. 1+N+kP,
  - WR in cycle (k+1)P.
- done is high in cycle DIMENSION*P+1. busy is high in cycles 1..DIMENSION*P+1.
- Defaults (N=8, P=10): WR for column k in cycle 10k+10; done in cycle 161. start can be accepted again at the edge ending cycle 162.

## Test plan
- Reset, then start pulse with defaults → exactly 16 wr_en pulses in cycles 10,20,…,160 with wr_addr 0..15 in order; done only in cycle 161; busy high in cycles 1–161.
- Each CLR/RUN window checks e_col: slice k == 8'sd1 and all other slices 0; eng_en high for exactly 8 cycles per column; eng_clr high exactly 1 cycle before each RUN.
- Drive eng_result = {16{col_idx+8'sd3}}-style pattern → wr_data for column k equals the pattern value presented in the last RUN cycle of column k.
- abort asserted in RUN of column 5 → next cycle IDLE, busy=0, eng_en=0, no further wr_en, no done; a new start then restarts at column 0.
- start held high continuously across a full run → no restart while busy; the second sequence begins with CLR in cycle 163.
- rst=0 in a WR cycle (column 3) → wr_en=0 in that cycle's registered output at the next edge, all outputs at reset values, and no done pulse.

Source files
------------

// File: rtl/mrd_col_sched.sv
// mrd_col_sched: time-shares one MRD_inv engine across all columns
// of the inverse, one unit vector / clear / run window / write per column.
module mrd_col_sched #(
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 8,
  parameter int ITER_NUM  = 2,
  parameter int ENG_LAT   = 4,
  parameter int ONE       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DIMENSION)-1:0] col_idx,
  output logic [DIMENSION*WIDTH-1:0]   e_col,
  output logic                         eng_clr,
  output logic                         eng_en,
  input  logic [DIMENSION*WIDTH-1:0]   eng_result,
  output logic                         wr_en,
  output logic [$clog2(DIMENSION)-1:0] wr_addr,
  output logic [DIMENSION*WIDTH-1:0]   wr_data
);

  localparam int N  = ITER_NUM * ENG_LAT;
  localparam int CW = $clog2(N) + 1;
  localparam int IW = $clog2(DIMENSION);
  localparam int DW = DIMENSION * WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(ONE);
  localparam logic [IW-1:0]    LAST  = IW'(DIMENSION - 1);
  localparam logic [CW-1:0]    CLAST = CW'(N - 1);

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic [CW-1:0] cnt;

  function automatic logic [DW-1:0] unit_vec(input logic [IW-1:0] k);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DIMENSION; i++) begin
      if (IW'(i) == k) v[i*WIDTH +: WIDTH] = ONE_W;
    end
    return v;
  endfunction

  assign wr_addr = col_idx;

  // next-state decode; abort from any active state wins over everything
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start) nxt = S_CLR;
      S_CLR:  nxt = S_RUN;
      S_RUN:  if (cnt == CLAST) nxt = S_WR;
      S_WR:   nxt = (col_idx == LAST) ? S_DONE : S_CLR;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) nxt = S_IDLE;
  end

  // state, counter and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      eng_clr <= 1'b0;
      eng_en  <= 1'b0;
      wr_en   <= 1'b0;
      col_idx <= '0;
      e_col   <= '0;
      wr_data <= '0;
    end else begin
      state   <= nxt;
      cnt     <= (state == S_RUN) ? cnt + 1'b1 : '0;
      busy    <= (nxt != S_IDLE);
      done    <= (nxt == S_DONE);
      eng_clr <= (nxt == S_CLR);
      eng_en  <= (nxt == S_RUN);
      wr_en   <= (nxt == S_WR);
      if (nxt == S_IDLE) begin
        col_idx <= '0;
        e_col   <= '0;
      end else if (state == S_IDLE) begin
        col_idx <= '0;
        e_col   <= unit_vec('0);
      end else if (state == S_WR && nxt == S_CLR) begin
        col_idx <= col_idx + 1'b1;
        e_col   <= unit_vec(col_idx + 1'b1);
      end
      if (state == S_RUN && nxt == S_WR) wr_data <= eng_result;
    end
  end

endmodule

// File: tb/tb_mrd_col_sched.sv
// tb_mrd_col_sched: random and directed stimulus against a
// cycle-position model of the column schedule.
module tb_mrd_col_sched;

  localparam int D  = 16;
  localparam int W  = 8;
  localparam int N  = 8;
  localparam int P  = N + 2;
  localparam int IW = 4;
  localparam int DW = D * W;
  localparam int TEND = D * P + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic [IW-1:0] col_idx;
  logic [DW-1:0] e_col;
  logic          eng_clr;
  logic          eng_en;
  logic [DW-1:0] eng_result;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  mrd_col_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .col_idx(col_idx), .e_col(e_col),
    .eng_clr(eng_clr), .eng_en(eng_en), .eng_result(eng_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // model: position t (1-based cycle) inside an accepted sequence
  bit            act = 0;
  int            t = 0;
  int            tstart = 0;
  logic [DW-1:0] wd = '0;

  int wr_q[$];
  int clr_q[$];
  int done_q[$];

  function automatic logic [DW-1:0] unit_of(input int k);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) if (i == k) v[i*W +: W] = 8'sd1;
    return v;
  endfunction

  function automatic logic [DW-1:0] pat(input int k);
    logic [DW-1:0] v;
    for (int i = 0; i < D; i++) v[i*W +: W] = W'(k + 3);
    return v;
  endfunction

  function automatic int mk();
    return (t <= D * P) ? (t - 1) / P : D - 1;
  endfunction

  function automatic int mr();
    return (t - 1) % P;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic compare();
    bit in_col;
    int k;
    int r;
    in_col = act && t <= D * P;
    k = act ? mk() : 0;
    r = act ? mr() : 0;
    chk("busy", DW'(busy), DW'(act));
    chk("done", DW'(done), DW'(act && t == TEND));
    chk("eng_clr", DW'(eng_clr), DW'(in_col && r == 0));
    chk("eng_en", DW'(eng_en), DW'(in_col && r >= 1 && r <= N));
    chk("wr_en", DW'(wr_en), DW'(in_col && r == N + 1));
    chk("col_idx", DW'(col_idx), DW'(k));
    chk("e_col", e_col, act ? unit_of(k) : '0);
    chk("wr_data", wr_data, wd);
    if (in_col && r == N + 1) chk("wr_addr", DW'(wr_addr), DW'(k));
    if (wr_en) wr_q.push_back(cyc);
    if (eng_clr) clr_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
  endtask

  task automatic step(input logic s, input logic a, input logic r,
                      input logic [DW-1:0] res);
    @(negedge clk);
    start = s;
    abort = a;
    rst = r;
    eng_result = res;
    @(posedge clk);
    cyc++;
    if (!r) begin
      act = 0; t = 0; wd = '0;
    end else if (act) begin
      if (a || t == TEND) begin
        act = 0; t = 0;
      end else begin
        t++;
      end
    end else if (s) begin
      act = 1; t = 1; tstart = cyc;
    end
    if (act && t <= D * P && t % P == 0) wd = res;
    #1;
    compare();
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  int e0;
  int base;

  initial begin
    start = 0; abort = 0; rst = 0; eng_result = '0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, rnd());
    chk("rst_wr_addr", DW'(wr_addr), '0);
    chk("rst_wr_data", wr_data, '0);
    step(0, 1, 1, rnd());

    // full sequence, per-column pattern on eng_result
    wr_q.delete(); clr_q.delete(); done_q.delete();
    step(1, 0, 1, pat(0));
    e0 = tstart;
    for (int i = 0; i < 170; i++) begin
      step(0, 0, 1, pat(act ? mk() : 0));
      if (act && t <= D * P && t % P == 0)
        chk("pat_wr_data", wr_data, pat(mk()));
    end
    chk("n_wr", DW'(wr_q.size()), DW'(16));
    chk("wr0_cyc", DW'(wr_q[0] - e0 + 1), DW'(10));
    chk("wr15_cyc", DW'(wr_q[15] - e0 + 1), DW'(160));
    chk("n_done", DW'(done_q.size()), DW'(1));
    chk("done_cyc", DW'(done_q[0] - e0 + 1), DW'(161));

    // abort inside RUN of column 5
    wr_q.delete(); done_q.delete();
    step(1, 0, 1, rnd());
    for (int i = 0; i < 53; i++) step(0, 0, 1, rnd());
    chk("abort_pos", DW'(t), DW'(54));
    step(0, 1, 1, rnd());
    chk("abort_busy", DW'(busy), '0);
    for (int i = 0; i < 40; i++) step(0, 0, 1, rnd());
    chk("abort_n_wr", DW'(wr_q.size()), DW'(5));
    chk("abort_n_done", DW'(done_q.size()), '0);
    step(1, 0, 1, rnd());
    chk("restart_col", DW'(col_idx), '0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, rnd());
    step(0, 1, 1, rnd());

    // start held high through a whole run
    clr_q.delete();
    step(1, 0, 1, rnd());
    base = cyc;
    for (int i = 0; i < 170; i++) step(1, 0, 1, rnd());
    chk("held_clr0", DW'(clr_q[0] - base + 1), DW'(1));
    chk("held_clr16", DW'(clr_q[16] - base + 1), DW'(163));
    step(0, 1, 1, rnd());

    // reset during the WR cycle of column 3
    done_q.delete();
    step(1, 0, 1, rnd());
    for (int i = 0; i < 39; i++) step(0, 0, 1, rnd());
    chk("rst_wr_addr3", DW'(wr_addr), DW'(3));
    step(0, 0, 0, rnd());
    chk("rstwr_wr_en", DW'(wr_en), '0);
    chk("rstwr_wr_data", wr_data, '0);
    for (int i = 0; i < 30; i++) step(0, 0, 1, rnd());
    chk("rstwr_n_done", DW'(done_q.size()), '0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(19) == 0, $urandom_range(199) == 0,
           $urandom_range(499) != 0, rnd());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
